// File: rtl/axi_trans_tracker.sv
// axi_trans_tracker: per-master AXI transaction tracker placed in front of the
// two-master arbiter. It raises a request when a write or read address is
// pending. The request is held through the granted burst, and endtrans pulses
// for one cycle when the burst completes. The observed beat count is checked
// against AWLEN/ARLEN.
//
// Ports:
//   clk_i, rstn_i              clock (rising edge), async active-low reset
//   grant_i                    arbiter grant for this master
//   aw*/w*/b*/ar*/r* _i        master/slave handshake signals being observed
//   sel_o                      request to arbiter
//   endtrans_o                 one-cycle pulse on transaction completion
//   busy_o                     granted transaction in progress
//   len_err_o                  sticky burst-length mismatch flag
module axi_trans_tracker #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             grant_i,
    input  logic             awvalid_i,
    input  logic             awready_i,
    input  logic [LEN_W-1:0] awlen_i,
    input  logic             wvalid_i,
    input  logic             wready_i,
    input  logic             wlast_i,
    input  logic             bvalid_i,
    input  logic             bready_i,
    input  logic             arvalid_i,
    input  logic             arready_i,
    input  logic [LEN_W-1:0] arlen_i,
    input  logic             rvalid_i,
    input  logic             rready_i,
    input  logic             rlast_i,
    output logic             sel_o,
    output logic             endtrans_o,
    output logic             busy_o,
    output logic             len_err_o
);

    localparam int unsigned CntW = LEN_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWr,
        StWresp,
        StRd,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              is_write_q, is_write_d;
    logic              aw_done_q, aw_done_d;  // also used as AR-done on reads
    logic              w_done_q, w_done_d;
    logic              len_err_q, len_err_d;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [CntW-1:0]   cnt_inc;

    // Handshakes are qualified with the done flags so a repeated AW/AR or
    // trailing W beats after wlast do not disturb the stored burst state.
    assign aw_hs = awvalid_i & awready_i & ~aw_done_q;
    assign w_hs  = wvalid_i & wready_i & ~w_done_q;
    assign b_hs  = bvalid_i & bready_i;
    assign ar_hs = arvalid_i & arready_i & ~aw_done_q;
    // R data cannot legally precede its address; such beats are ignored.
    assign r_hs  = rvalid_i & rready_i & aw_done_q;

    // Saturating increment: a runaway burst pins at all-ones, never wraps.
    assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

    // State register and datapath flops.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            is_write_q <= is_write_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            len_err_q  <= len_err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        is_write_d = is_write_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        len_err_d  = len_err_q;

        unique case (state_q)
            StIdle: begin
                // Write has priority when both address channels are valid.
                if (awvalid_i) begin
                    is_write_d = 1'b1;
                    state_d    = StReq;
                end else if (arvalid_i) begin
                    is_write_d = 1'b0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (grant_i) begin
                    state_d   = is_write_q ? StWr : StRd;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    len_err_d = 1'b0;
                end
            end
            StWr: begin
                if (aw_hs) begin
                    len_d     = awlen_i;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    cnt_d = cnt_inc;
                    if (wlast_i) begin
                        w_done_d = 1'b1;
                    end
                end
                // Compare once both the address and the last beat are in,
                // whichever arrives second, including same-cycle arrivals.
                if (aw_done_d && w_done_d) begin
                    if (cnt_d != ({1'b0, len_d} + CntW'(1))) begin
                        len_err_d = 1'b1;
                    end
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if (b_hs) begin
                    state_d = StDone;
                end
            end
            StRd: begin
                if (ar_hs) begin
                    len_d     = arlen_i;
                    aw_done_d = 1'b1;
                end
                if (r_hs) begin
                    cnt_d = cnt_inc;
                    if (rlast_i) begin
                        if (cnt_inc != ({1'b0, len_q} + CntW'(1))) begin
                            len_err_d = 1'b1;
                        end
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the registered state, so they are glitch-free.
    always_comb begin
        sel_o      = 1'b0;
        endtrans_o = 1'b0;
        busy_o     = 1'b0;
        len_err_o  = len_err_q;
        unique case (state_q)
            StReq: begin
                sel_o = 1'b1;
            end
            StWr, StWresp, StRd: begin
                sel_o  = 1'b1;
                busy_o = 1'b1;
            end
            StDone: begin
                endtrans_o = 1'b1;
            end
            default: begin
                sel_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_trans_tracker.sv
// Directed testbench for axi_trans_tracker. Each check compares the packed
// output vector {sel, endtrans, busy, len_err} against a hand-computed value.
module tb_axi_trans_tracker;

    localparam int unsigned LEN_W = 8;

    logic             clk;
    logic             rstn;
    logic             grant;
    logic             awvalid, awready;
    logic [LEN_W-1:0] awlen;
    logic             wvalid, wready, wlast;
    logic             bvalid, bready;
    logic             arvalid, arready;
    logic [LEN_W-1:0] arlen;
    logic             rvalid, rready, rlast;
    logic             sel, endtrans, busy, len_err;

    int vec_cnt;
    int err_cnt;

    axi_trans_tracker #(
        .LEN_W(LEN_W)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .grant_i   (grant),
        .awvalid_i (awvalid),
        .awready_i (awready),
        .awlen_i   (awlen),
        .wvalid_i  (wvalid),
        .wready_i  (wready),
        .wlast_i   (wlast),
        .bvalid_i  (bvalid),
        .bready_i  (bready),
        .arvalid_i (arvalid),
        .arready_i (arready),
        .arlen_i   (arlen),
        .rvalid_i  (rvalid),
        .rready_i  (rready),
        .rlast_i   (rlast),
        .sel_o     (sel),
        .endtrans_o(endtrans),
        .busy_o    (busy),
        .len_err_o (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // exp is {sel, endtrans, busy, len_err}
    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {sel, endtrans, busy, len_err};
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rstn = 1'b0; grant = 1'b0;
        awvalid = 1'b0; awready = 1'b0; awlen = '0;
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        bvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arready = 1'b0; arlen = '0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;

        #12;
        chk("reset", 4'b0000);
        tick();
        rstn = 1'b1;
        grant = 1'b1;
        tick();
        chk("idle_grant_ignored", 4'b0000);
        grant = 1'b0;

        // 1: write awlen=3, four beats, B handshake
        awvalid = 1'b1; awlen = 8'd3;
        tick();
        chk("w1_req", 4'b1000);
        tick();
        chk("w1_req_hold", 4'b1000);
        grant = 1'b1;
        tick();
        chk("w1_wr", 4'b1010);
        grant = 1'b0; awready = 1'b1; wvalid = 1'b1; wready = 1'b1;
        tick();
        chk("w1_beat1", 4'b1010);
        awvalid = 1'b0; awready = 1'b0;
        tick();
        chk("w1_beat2", 4'b1010);
        tick();
        chk("w1_beat3", 4'b1010);
        wlast = 1'b1;
        tick();
        chk("w1_wresp", 4'b1010);
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        tick();
        chk("w1_wait_b", 4'b1010);
        bvalid = 1'b1; bready = 1'b1;
        tick();
        chk("w1_done", 4'b0100);
        bvalid = 1'b0; bready = 1'b0;
        tick();
        chk("w1_idle", 4'b0000);

        // 2: read arlen=0, single beat
        arvalid = 1'b1; arlen = 8'd0;
        tick();
        chk("r1_req", 4'b1000);
        grant = 1'b1;
        tick();
        chk("r1_rd", 4'b1010);
        grant = 1'b0; arready = 1'b1;
        tick();
        chk("r1_ar", 4'b1010);
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        tick();
        chk("r1_done", 4'b0100);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        tick();
        chk("r1_idle", 4'b0000);

        // 3: simultaneous AW and AR, write first, read two cycles after endtrans
        awvalid = 1'b1; awlen = 8'd0; arvalid = 1'b1; arlen = 8'd0;
        tick();
        chk("both_req", 4'b1000);
        grant = 1'b1;
        tick();
        chk("both_wr", 4'b1010);
        grant = 1'b0; awready = 1'b1;
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
        tick();
        chk("both_wresp", 4'b1010);
        awvalid = 1'b0; awready = 1'b0;
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        bvalid = 1'b1; bready = 1'b1;
        tick();
        chk("both_w_done", 4'b0100);
        bvalid = 1'b0; bready = 1'b0;
        tick();
        chk("both_gap", 4'b0000);
        tick();
        chk("both_rd_req", 4'b1000);
        grant = 1'b1;
        tick();
        chk("both_rd", 4'b1010);
        grant = 1'b0; arready = 1'b1;
        tick();
        chk("both_ar", 4'b1010);
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        tick();
        chk("both_r_done", 4'b0100);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        tick();
        chk("both_idle", 4'b0000);

        // 4: write awlen=3 ends early on beat 2 -> len_err sticky until next grant
        awvalid = 1'b1; awlen = 8'd3;
        tick();
        chk("short_req", 4'b1000);
        grant = 1'b1;
        tick();
        grant = 1'b0; awready = 1'b1; wvalid = 1'b1; wready = 1'b1;
        tick();
        chk("short_beat1", 4'b1010);
        awvalid = 1'b0; awready = 1'b0; wlast = 1'b1;
        tick();
        chk("short_err", 4'b1011);
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        bvalid = 1'b1; bready = 1'b1;
        tick();
        chk("short_done", 4'b0101);
        bvalid = 1'b0; bready = 1'b0;
        tick();
        chk("short_idle", 4'b0001);
        arvalid = 1'b1; arlen = 8'd1;
        tick();
        chk("short_next_req", 4'b1001);
        grant = 1'b1;
        tick();
        chk("short_err_clr", 4'b1010);
        grant = 1'b0; arready = 1'b1;
        tick();
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1;
        tick();
        chk("r2_beat1", 4'b1010);
        rlast = 1'b1;
        tick();
        chk("r2_done", 4'b0100);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        tick();
        chk("r2_idle", 4'b0000);

        // 5: W beats before AW handshake, awlen=1
        awvalid = 1'b1; awlen = 8'd1;
        tick();
        grant = 1'b1;
        tick();
        chk("early_wr", 4'b1010);
        grant = 1'b0; wvalid = 1'b1; wready = 1'b1;
        tick();
        chk("early_beat1", 4'b1010);
        wlast = 1'b1;
        tick();
        chk("early_wait_aw", 4'b1010);
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0;
        awready = 1'b1;
        tick();
        chk("early_wresp", 4'b1010);
        awvalid = 1'b0; awready = 1'b0;
        bvalid = 1'b1; bready = 1'b1;
        tick();
        chk("early_done", 4'b0100);
        bvalid = 1'b0; bready = 1'b0;
        tick();
        chk("early_idle", 4'b0000);

        // 6: reset mid-read, then a short read flags len_err
        arvalid = 1'b1; arlen = 8'd3;
        tick();
        grant = 1'b1;
        tick();
        grant = 1'b0; arready = 1'b1;
        tick();
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1;
        tick();
        chk("rst_pre", 4'b1010);
        rstn = 1'b0;
        #1;
        chk("rst_async", 4'b0000);
        rvalid = 1'b0; rready = 1'b0;
        tick();
        chk("rst_hold", 4'b0000);
        rstn = 1'b1;
        tick();
        chk("rst_release", 4'b0000);
        arvalid = 1'b1;
        tick();
        chk("rst_new_req", 4'b1000);
        grant = 1'b1;
        tick();
        grant = 1'b0; arready = 1'b1;
        tick();
        arvalid = 1'b0; arready = 1'b0;
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        tick();
        chk("rshort_done", 4'b0101);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        tick();
        chk("rshort_idle", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/axi_trans_tracker.md
Name: axi_trans_tracker

Overview:
- Per-master transaction tracker; one instance per master port, sitting directly upstream of the two-master arbitration unit.
- Watches the master's AXI handshakes and raises a request (sel) when a write or read address is pending.
- Holds the request through the granted transaction and pulses endtrans exactly once when the burst completes (B handshake for writes, last R handshake for reads).
- Also checks burst length against AWLEN/ARLEN and flags mismatches.

Parameters:
- LEN_W, 8, width of AWLEN/ARLEN and of the internal beat counter (AXI4 burst length field).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous active-low reset
- grant  input  1  this master is granted by the arbiter (mas_sel bit for this master)
- awvalid  input  1  master AW valid
- awready  input  1  slave AW ready (as routed back through the interconnect)
- awlen  input  LEN_W  AW burst length minus one
- wvalid  input  1  W valid
- wready  input  1  W ready
- wlast  input  1  W last
- bvalid  input  1  B valid
- bready  input  1  B ready
- arvalid  input  1  AR valid
- arready  input  1  AR ready
- arlen  input  LEN_W  AR burst length minus one
- rvalid  input  1  R valid
- rready  input  1  R ready
- rlast  input  1  R last
- sel  output  1  request to arbiter
- endtrans  output  1  one-cycle pulse: transaction complete
- busy  output  1  granted transaction in progress
- len_err  output  1  sticky burst-length mismatch, cleared at next transaction start

Behaviour:
- Reset (rstn low, async): state=IDLE; sel=0, endtrans=0, busy=0, len_err=0; beat counter=0, is_write=0, aw_done=0, w_done=0, stored length=0. Reset mid-transaction aborts silently; no endtrans is issued.
- Handshake definition: a handshake is X_valid & X_ready sampled on a rising clk edge.
- Outputs: registered, decoded from state plus flags.
- IDLE:
  - awvalid=1 -> REQ with is_write=1.
  - else arvalid=1 -> REQ with is_write=0. Write wins when both are valid in the same cycle.
  - sel=0.
- REQ:
  - sel=1.
  - grant=1 -> WR or RD per is_write; clear counter, aw_done, w_done, len_err.
  - Otherwise stay; sel stays high.
- WR (busy=1, sel=1):
  - AW handshake: store awlen, set aw_done.
  - Each W handshake: counter+1. W beats arriving before the AW handshake are counted.
  - W handshake with wlast=1: set w_done; compare counter+1 against stored length+1. If AW has not completed yet, compare when it completes. Any mismatch sets len_err.
  - Leave for WRESP when aw_done and w_done are both set; an AW/last-W handshake in the current cycle counts.
- WRESP (busy=1, sel=1): B handshake -> DONE.
- RD (busy=1, sel=1):
  - AR handshake: store arlen, set aw_done, which is reused as the address-done flag.
  - Each R handshake: counter+1.
  - R handshake with rlast=1: compare against arlen+1, set len_err on mismatch, -> DONE.
  - R beats before the AR handshake are ignored.
- DONE: endtrans=1 for exactly this one cycle; sel=0, busy=0; -> IDLE unconditionally.
  - The arbiter samples endtrans while still in its grant state and releases on the next edge.
  - A new request is visible in IDLE one cycle later, giving a minimum of 2 idle cycles between transactions from the same master.
- Grant timing: grant deassert while in WR/WRESP/RD is ignored; the transaction still completes. Grant asserted in IDLE is ignored.
- Counter: LEN_W+1 bits, saturating at all-ones; no wrap.
- Outstanding transactions: a second AW/AR while busy is not tracked. Only one outstanding transaction per master is supported by design.

Test Plan:
- Write, awlen=3, grant one cycle after sel, 4 W beats with wlast on the 4th, then B handshake -> sel high from the cycle after awvalid; endtrans one pulse in the cycle after B; len_err=0.
- Read, arlen=0, single R beat with rlast -> endtrans pulse in the cycle after the R handshake; busy high only while in RD.
- awvalid and arvalid both high from IDLE -> write handled first. After endtrans, sel re-asserts two cycles later for the read, which completes with its own endtrans.
- Write, awlen=3, wlast on the 2nd beat -> len_err=1 held through DONE and IDLE; cleared when the next transaction is granted.
- W beats issued before the AW handshake (awlen=1, 2 beats, then AW) -> goes to WRESP the cycle after the AW handshake; len_err=0.
- rstn pulsed low mid-RD -> all outputs 0 immediately, no endtrans pulse; after release a fresh arvalid restarts from IDLE -> REQ.
